linebuf_sequencer: RTL and testbench
====================================

Name: linebuf_sequencer

Overview:
- Timing and control sequencer for the red-tracking 3-line search datapath.
- Owns pixel/column/row counting, the rotating 3-line write select and the ping-pong bank select.
- Also generates the read-window valid strobe and frame start/done pulses, so line buffers and the 3x3 detector only act on decoded strobes.
- Sits between the video-input timing (vref, href2, href2_wr, oddframe) and the line-buffer/search logic.

Parameters:
- H_ACTIVE, 180, active pixels per line.
- V_ACTIVE, 120, active lines per processed frame.
- ADR_W, 16, width of the frame pixel address.

Ports:
- clk_llc8, in, 1, pixel clock.
- resetx, in, 1, asynchronous active-low reset.
- vref, in, 1, vertical sync; rising edge marks frame start.
- oddframe, in, 1, high = current field is processed; even fields are skipped.
- href2, in, 1, line active window.
- href2_wr, in, 1, pixel write strobe (one per pixel).
- adr_counter, out, ADR_W, frame pixel address of the current pixel slot.
- col, out, 8, column 0..H_ACTIVE-1 of the current slot.
- row, out, 8, row 0..V_ACTIVE-1.
- wr_sel, out, 3, one-hot line select inside the active bank.
- bank_sel, out, 1, bank being written (0 = LB1-3, 1 = LB4-6).
- win_valid, out, 1, 3x3 window at col-1..col+1 of the idle bank is evaluable this cycle.
- frame_start, out, 1, one-cycle pulse on an accepted frame start.
- frame_done, out, 1, one-cycle pulse when row V_ACTIVE-1 completes.
- err_ovf, out, 1, sticky: extra pixel beyond H_ACTIVE in a line.
- err_short, out, 1, sticky: line ended with 0 < col < H_ACTIVE.

Behaviour:
- Reset values (resetx=0, asynchronous):
  - All counters 0, wr_sel=3'b001, bank_sel=0.
  - full[1:0]=0, all pulses 0, errors 0, FSM=IDLE.
- Edge detection: vref and href2 registered once; rise/fall are derived from the registered vs. current value.
- Accepted frame start: vref rise with oddframe=1. In any state it:
  - zeroes the counters, wr_sel=001, bank_sel=0, full=0;
  - clears the error flags;
  - pulses frame_start the next cycle;
  - moves the FSM to WAIT_LINE.
  - A start arriving mid-frame aborts the current frame, with no frame_done.
- vref rise with oddframe=0: the FSM goes to IDLE and no outputs change.
- FSM states:
  - IDLE: waits for an accepted start.
  - WAIT_LINE: href2 rise -> LINE.
  - LINE: counts pixels; href2 fall -> line-end processing, then WAIT_LINE, or DONE if the finished row was V_ACTIVE-1.
  - DONE: ignores href2/href2_wr until the next accepted start.
- Addressing (zero latency):
  - adr_counter/col/row are registered and hold the address of the pixel whose href2_wr is high in the same cycle.
  - They advance on the clock edge where href2_wr=1 in LINE.
- Pixel with col = H_ACTIVE-1:
  - col wraps to 0.
  - row, wr_sel and bank_sel do not change yet; that is line-end work.
  - A flag line_full is set.
- Pixel while line_full=1: ignored (no address advance), err_ovf set.
- Line end (href2 fall in LINE):
  - col != 0 and line_full=0 -> err_short set; adr_counter jumps to row*H_ACTIVE+H_ACTIVE, i.e. the line is padded.
  - row increments; col=0; line_full cleared.
  - wr_sel rotates 001->010->100->001.
  - When wr_sel was 100: full[bank_sel] is set, bank_sel toggles, and full[new bank] is cleared.
  - A line end with col=0 and line_full=0 (empty href2 pulse) is ignored entirely.
- win_valid = (state==LINE) & href2_wr & full[~bank_sel] & (1 <= col <= H_ACTIVE-2). The search reads the idle bank at col-1, col and col+1.
- frame_done: one-cycle pulse on the cycle after the line end of row V_ACTIVE-1; the FSM enters DONE. row stays at V_ACTIVE-1 and adr_counter = H_ACTIVE*V_ACTIVE.
- Arithmetic:
  - adr_counter is unsigned; its maximum is H_ACTIVE*V_ACTIVE = 21600, which fits ADR_W.
  - There is no modulo logic; col is a separate counter.
- Simultaneous events:
  - An accepted start in the same cycle as href2_wr: the start wins and the pixel is dropped.
  - href2 rise and fall cannot coincide (registered edges).

Decomposition:
- Package linebuf_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults;
  - FSM state encoding (IDLE, WAIT_LINE, LINE, DONE);
  - WR_SEL_INIT=3'b001;
  - the width function for col/row.
- One natural sub-module: sync_edge_det (register + rise/fall outputs), instanced for vref and href2.

Test Plan:
- Reset mid-LINE at col=57 -> all outputs return to reset values asynchronously. Next accepted start -> adr_counter=0, frame_start pulses once.
- Odd frame, 120 lines x 180 href2_wr -> check:
  - adr_counter reaches 21599 on the last pixel;
  - wr_sel sequence 001,010,100 repeats;
  - bank_sel toggles after rows 2, 5, 8, ...;
  - frame_done is a single pulse after row 119;
  - err flags stay 0.
- win_valid -> low throughout rows 0-2. From row 3 it is high exactly for col 1..178 (178 cycles per line).
- Line of 181 pixels -> pixel 181 dropped, err_ovf=1, next line starts at adr_counter=180*(row+1). Line of 100 pixels -> err_short=1, next row starts at col=0 and adr_counter=(row+1)*180.
- vref rise with oddframe=0 -> FSM IDLE, 10 lines of href2_wr produce no counter change and no win_valid.
- Accepted start at row 40 -> no frame_done; counters, wr_sel, bank_sel and full are reset; frame_start pulses.

Source files
------------

// File: rtl/linebuf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : linebuf_pkg                                               |
// | Purpose  : Shared geometry defaults, sequencer FSM encoding and the  |
// |            counter width helper for the 3-line search sequencer.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package linebuf_pkg;

  localparam int H_ACTIVE_DEF = 180;
  localparam int V_ACTIVE_DEF = 120;
  localparam int ADR_W_DEF    = 16;

  // One-hot select of the first line inside a bank.
  localparam logic [2:0] WR_SEL_INIT = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_LINE      = 2'd2,
    ST_DONE      = 2'd3
  } seq_state_t;

  // Smallest width able to hold 0..max_count-1 (at least 1 bit).
  function automatic int cnt_width(input int max_count);
    int w;
    w = 1;
    while ((1 << w) < max_count) w++;
    return w;
  endfunction

  // Column/row counter width; the default line length sets it to 8 bits.
  localparam int CNT_W = cnt_width(H_ACTIVE_DEF);

endpackage
`default_nettype wire

// File: rtl/linebuf_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : linebuf_sequencer_if                                      |
// | Purpose  : Video timing inputs and decoded line-buffer strobes of    |
// |            the line-buffer sequencer.                                |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface linebuf_sequencer_if #(
  parameter int ADR_W = 16
);
  import linebuf_pkg::*;

  logic             vref;
  logic             oddframe;
  logic             href2;
  logic             href2_wr;
  logic [ADR_W-1:0] adr_counter;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic [2:0]       wr_sel;
  logic             bank_sel;
  logic             win_valid;
  logic             frame_start;
  logic             frame_done;
  logic             err_ovf;
  logic             err_short;

  // Video timing source side.
  modport master (
    output vref, oddframe, href2, href2_wr,
    input  adr_counter, col, row, wr_sel, bank_sel, win_valid,
           frame_start, frame_done, err_ovf, err_short
  );

  // Sequencer side.
  modport slave (
    input  vref, oddframe, href2, href2_wr,
    output adr_counter, col, row, wr_sel, bank_sel, win_valid,
           frame_start, frame_done, err_ovf, err_short
  );

endinterface
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sync_edge_det                                             |
// | Purpose  : Registers a level once and flags its rise/fall by         |
// |            comparing the current level with the registered one.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sync_edge_det (
  input  wire logic clk_llc8,
  input  wire logic resetx,
  input  wire logic d,
  output logic      rise,
  output logic      fall
);

  logic r_d;

  // One-cycle history of the input level.
  always_ff @(posedge clk_llc8 or negedge resetx) begin
    if (!resetx) r_d <= 1'b0;
    else         r_d <= d;
  end

  assign rise = d & ~r_d;
  assign fall = ~d & r_d;

endmodule
`default_nettype wire

// File: rtl/linebuf_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : linebuf_sequencer                                         |
// | Purpose  : Pixel/column/row counting, rotating 3-line write select,  |
// |            ping-pong bank select, 3x3 read-window strobe and frame   |
// |            start/done pulses for the red-tracking search datapath.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module linebuf_sequencer
  import linebuf_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADR_W    = ADR_W_DEF
) (
  input wire logic        clk_llc8,
  input wire logic        resetx,
  linebuf_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] c_last_col     = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] c_win_last_col = CNT_W'(H_ACTIVE - 2);
  localparam logic [CNT_W-1:0] c_last_row     = CNT_W'(V_ACTIVE - 1);

  seq_state_t       r_state;
  logic [ADR_W-1:0] r_adr;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic [2:0]       r_wr_sel;
  logic             r_bank_sel;
  logic [1:0]       r_full;
  logic             r_line_full;
  logic             r_frame_start;
  logic             r_frame_done;
  logic             r_err_ovf;
  logic             r_err_short;

  logic             w_vref_rise;
  logic             w_vref_fall_unused;
  logic             w_href_rise;
  logic             w_href_fall;
  logic             w_start;
  logic [ADR_W-1:0] w_next_line_adr;

  sync_edge_det u_vref_edge (
    .clk_llc8 (clk_llc8),
    .resetx   (resetx),
    .d        (bus.vref),
    .rise     (w_vref_rise),
    .fall     (w_vref_fall_unused)
  );

  sync_edge_det u_href_edge (
    .clk_llc8 (clk_llc8),
    .resetx   (resetx),
    .d        (bus.href2),
    .rise     (w_href_rise),
    .fall     (w_href_fall)
  );

  // Only odd fields are processed; an even-field vsync merely parks the FSM.
  assign w_start = w_vref_rise & bus.oddframe;

  // First address of the following row; also pads out a short line.
  assign w_next_line_adr = ADR_W'(r_row) * ADR_W'(H_ACTIVE) + ADR_W'(H_ACTIVE);

  // Frame/line sequencing: counters, line rotation, bank swap and error flags.
  always_ff @(posedge clk_llc8 or negedge resetx) begin
    if (!resetx) begin
      r_state       <= ST_IDLE;
      r_adr         <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_wr_sel      <= WR_SEL_INIT;
      r_bank_sel    <= 1'b0;
      r_full        <= 2'b00;
      r_line_full   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err_ovf     <= 1'b0;
      r_err_short   <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      if (w_start) begin
        // Accepted start wins over everything, including a pixel this cycle.
        r_state       <= ST_WAIT_LINE;
        r_adr         <= '0;
        r_col         <= '0;
        r_row         <= '0;
        r_wr_sel      <= WR_SEL_INIT;
        r_bank_sel    <= 1'b0;
        r_full        <= 2'b00;
        r_line_full   <= 1'b0;
        r_err_ovf     <= 1'b0;
        r_err_short   <= 1'b0;
        r_frame_start <= 1'b1;
      end else if (w_vref_rise) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
          end
          ST_WAIT_LINE: begin
            if (w_href_rise) r_state <= ST_LINE;
          end
          ST_LINE: begin
            if (w_href_fall) begin
              // An empty href2 pulse (nothing written) is not a line.
              if ((r_col != '0) || r_line_full) begin
                if (!r_line_full) r_err_short <= 1'b1;
                r_adr       <= w_next_line_adr;
                r_col       <= '0;
                r_line_full <= 1'b0;
                r_wr_sel    <= {r_wr_sel[1:0], r_wr_sel[2]};
                if (r_wr_sel[2]) begin
                  r_full[r_bank_sel]  <= 1'b1;
                  r_full[~r_bank_sel] <= 1'b0;
                  r_bank_sel          <= ~r_bank_sel;
                end
                if (r_row == c_last_row) begin
                  r_state      <= ST_DONE;
                  r_frame_done <= 1'b1;
                end else begin
                  r_row   <= r_row + 1'b1;
                  r_state <= ST_WAIT_LINE;
                end
              end
            end else if (bus.href2_wr) begin
              if (r_line_full) begin
                r_err_ovf <= 1'b1;
              end else begin
                r_adr <= r_adr + 1'b1;
                if (r_col == c_last_col) begin
                  r_col       <= '0;
                  r_line_full <= 1'b1;
                end else begin
                  r_col <= r_col + 1'b1;
                end
              end
            end
          end
          ST_DONE: begin
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Window is evaluable only where col-1..col+1 all lie inside the idle bank's lines.
  assign bus.win_valid = (r_state == ST_LINE) & bus.href2_wr & r_full[~r_bank_sel]
                       & (r_col != '0) & (r_col <= c_win_last_col);

  assign bus.adr_counter = r_adr;
  assign bus.col         = r_col;
  assign bus.row         = r_row;
  assign bus.wr_sel      = r_wr_sel;
  assign bus.bank_sel    = r_bank_sel;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_done  = r_frame_done;
  assign bus.err_ovf     = r_err_ovf;
  assign bus.err_short   = r_err_short;

endmodule
`default_nettype wire

// File: tb/tb_linebuf_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_linebuf_sequencer                                      |
// | Purpose  : Self-checking bench for linebuf_sequencer against a       |
// |            line/pixel-index reference model.                         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_linebuf_sequencer;
  import linebuf_pkg::*;

  localparam int H  = 180;
  localparam int V  = 120;
  localparam int AW = 16;

  logic clk_llc8 = 1'b0;
  logic resetx   = 1'b0;

  always #5 clk_llc8 = ~clk_llc8;

  linebuf_sequencer_if #(.ADR_W(AW)) bus ();

  linebuf_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADR_W(AW)) dut (
    .clk_llc8 (clk_llc8),
    .resetx   (resetx),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame position in row/line terms.
  bit m_active;   // frame in progress, pixels are counted
  bit m_done;     // last row completed, line rotation no longer meaningful
  int m_row;      // current row
  int m_adr;      // held address while no frame is counting
  bit m_ovf;
  bit m_short;

  task automatic cycle();
    @(posedge clk_llc8);
    #1;
  endtask

  task automatic model_clear(input bit active);
    m_active = active; m_done = 1'b0; m_row = 0; m_adr = 0; m_ovf = 1'b0; m_short = 1'b0;
  endtask

  // Drives vref low then high with the given field parity and checks the start pulse.
  task automatic start_frame(input bit odd);
    logic [2:0] exp_wr;
    bus.vref = 1'b0;
    cycle();
    bus.vref = 1'b1; bus.oddframe = odd;
    cycle();
    if (odd) model_clear(1'b1);
    else     m_active = 1'b0;
    exp_wr = 3'b001 << (m_row % 3);
    n_checks++; if (bus.frame_start !== odd) begin n_fail++; $display("FAIL start_pulse odd=%b got=%b exp=%b", odd, bus.frame_start, odd); end
    n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL start_no_done got=%b exp=0", bus.frame_done); end
    n_checks++; if (bus.adr_counter !== 16'(m_adr)) begin n_fail++; $display("FAIL start_adr got=%0d exp=%0d", bus.adr_counter, m_adr); end
    n_checks++; if (bus.row !== 8'(m_row)) begin n_fail++; $display("FAIL start_row got=%0d exp=%0d", bus.row, m_row); end
    n_checks++; if (bus.col !== 8'd0) begin n_fail++; $display("FAIL start_col got=%0d exp=0", bus.col); end
    n_checks++; if ({bus.err_ovf, bus.err_short} !== {m_ovf, m_short}) begin n_fail++; $display("FAIL start_err got=%b%b exp=%b%b", bus.err_ovf, bus.err_short, m_ovf, m_short); end
    if (!m_done) begin
      n_checks++; if (bus.wr_sel !== exp_wr) begin n_fail++; $display("FAIL start_wr_sel got=%b exp=%b", bus.wr_sel, exp_wr); end
      n_checks++; if (bus.bank_sel !== 1'((m_row / 3) % 2)) begin n_fail++; $display("FAIL start_bank got=%b exp=%0d", bus.bank_sel, (m_row / 3) % 2); end
    end
    cycle();
    n_checks++; if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL start_pulse_width got=%b exp=0", bus.frame_start); end
  endtask

  // One href2 window carrying n pixel strobes (optionally with random idle cycles).
  task automatic drive_line(input int n, input bit gaps);
    int         wv_cnt, exp_wv_cnt, exp_col, exp_adr;
    bit         exp_wv, ended;
    logic [2:0] exp_wr;
    bus.href2 = 1'b1; bus.href2_wr = 1'b0;
    cycle();
    wv_cnt = 0;
    exp_wr = 3'b001 << (m_row % 3);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(3, 0) == 0)) begin
        bus.href2_wr = 1'b0; #1;
        n_checks++; if (bus.win_valid !== 1'b0) begin n_fail++; $display("FAIL gap_win_valid row=%0d i=%0d got=%b exp=0", m_row, i, bus.win_valid); end
        cycle();
      end
      bus.href2_wr = 1'b1; #1;
      if (m_active) begin
        exp_col = (i < H) ? i : 0;
        exp_adr = m_row * H + ((i < H) ? i : H);
        exp_wv  = (m_row >= 3) && (i >= 1) && (i <= H - 2);
      end else begin
        exp_col = 0; exp_adr = m_adr; exp_wv = 1'b0;
      end
      if (bus.win_valid === 1'b1) wv_cnt++;
      n_checks++; if (bus.col !== 8'(exp_col)) begin n_fail++; $display("FAIL pix_col row=%0d i=%0d got=%0d exp=%0d", m_row, i, bus.col, exp_col); end
      n_checks++; if (bus.adr_counter !== 16'(exp_adr)) begin n_fail++; $display("FAIL pix_adr row=%0d i=%0d got=%0d exp=%0d", m_row, i, bus.adr_counter, exp_adr); end
      n_checks++; if (bus.row !== 8'(m_row)) begin n_fail++; $display("FAIL pix_row i=%0d got=%0d exp=%0d", i, bus.row, m_row); end
      n_checks++; if (bus.win_valid !== exp_wv) begin n_fail++; $display("FAIL pix_win_valid row=%0d i=%0d got=%b exp=%b", m_row, i, bus.win_valid, exp_wv); end
      if (!m_done) begin
        n_checks++; if (bus.wr_sel !== exp_wr) begin n_fail++; $display("FAIL pix_wr_sel row=%0d got=%b exp=%b", m_row, bus.wr_sel, exp_wr); end
        n_checks++; if (bus.bank_sel !== 1'((m_row / 3) % 2)) begin n_fail++; $display("FAIL pix_bank row=%0d got=%b exp=%0d", m_row, bus.bank_sel, (m_row / 3) % 2); end
      end
      cycle();
    end
    bus.href2_wr = 1'b0; bus.href2 = 1'b0;
    exp_wv_cnt = (m_active && m_row >= 3) ? (((n - 1) < (H - 2)) ? (n - 1) : (H - 2)) : 0;
    if (exp_wv_cnt < 0) exp_wv_cnt = 0;
    n_checks++; if (wv_cnt !== exp_wv_cnt) begin n_fail++; $display("FAIL win_count row=%0d got=%0d exp=%0d", m_row, wv_cnt, exp_wv_cnt); end
    ended = 1'b0;
    if (m_active && n > 0) begin
      if (n < H) m_short = 1'b1;
      if (n > H) m_ovf = 1'b1;
      if (m_row == V - 1) begin
        m_active = 1'b0; m_done = 1'b1; m_adr = H * V; ended = 1'b1;
      end else begin
        m_row++; m_adr = m_row * H;
      end
    end
    cycle();
    n_checks++; if (bus.frame_done !== ended) begin n_fail++; $display("FAIL eol_frame_done row=%0d got=%b exp=%b", m_row, bus.frame_done, ended); end
    n_checks++; if (bus.adr_counter !== 16'(m_adr)) begin n_fail++; $display("FAIL eol_adr row=%0d got=%0d exp=%0d", m_row, bus.adr_counter, m_adr); end
    n_checks++; if (bus.col !== 8'd0) begin n_fail++; $display("FAIL eol_col got=%0d exp=0", bus.col); end
    n_checks++; if (bus.row !== 8'(m_row)) begin n_fail++; $display("FAIL eol_row got=%0d exp=%0d", bus.row, m_row); end
    n_checks++; if (bus.err_ovf !== m_ovf) begin n_fail++; $display("FAIL eol_err_ovf row=%0d got=%b exp=%b", m_row, bus.err_ovf, m_ovf); end
    n_checks++; if (bus.err_short !== m_short) begin n_fail++; $display("FAIL eol_err_short row=%0d got=%b exp=%b", m_row, bus.err_short, m_short); end
    cycle();
    n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_width got=%b exp=0", bus.frame_done); end
  endtask

  task automatic test_reset();
    repeat (3) cycle();
    n_checks++; if ({bus.adr_counter, bus.col, bus.row} !== 32'd0) begin n_fail++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", bus.adr_counter, bus.col, bus.row); end
    n_checks++; if ({bus.wr_sel, bus.bank_sel} !== 4'b0010) begin n_fail++; $display("FAIL reset_sel got=%b/%b exp=001/0", bus.wr_sel, bus.bank_sel); end
    resetx = 1'b1;
    model_clear(1'b0);
    cycle();
    start_frame(1'b1);
    bus.href2 = 1'b1;
    cycle();
    for (int i = 0; i < 57; i++) begin bus.href2_wr = 1'b1; cycle(); end
    bus.href2_wr = 1'b0; #1;
    n_checks++; if (bus.col !== 8'd57) begin n_fail++; $display("FAIL pre_reset_col got=%0d exp=57", bus.col); end
    n_checks++; if (bus.adr_counter !== 16'd57) begin n_fail++; $display("FAIL pre_reset_adr got=%0d exp=57", bus.adr_counter); end
    bus.href2_wr = 1'b1; #1;
    resetx = 1'b0; #1;
    n_checks++; if ({bus.adr_counter, bus.col, bus.row} !== 32'd0) begin n_fail++; $display("FAIL async_reset_counters got=%0d/%0d/%0d exp=0/0/0", bus.adr_counter, bus.col, bus.row); end
    n_checks++; if ({bus.wr_sel, bus.bank_sel} !== 4'b0010) begin n_fail++; $display("FAIL async_reset_sel got=%b/%b exp=001/0", bus.wr_sel, bus.bank_sel); end
    n_checks++; if ({bus.win_valid, bus.frame_start, bus.frame_done, bus.err_ovf, bus.err_short} !== 5'b0) begin n_fail++; $display("FAIL async_reset_flags got=%b exp=00000", {bus.win_valid, bus.frame_start, bus.frame_done, bus.err_ovf, bus.err_short}); end
    bus.href2_wr = 1'b0; bus.href2 = 1'b0;
    repeat (2) cycle();
    resetx = 1'b1;
    model_clear(1'b0);
    cycle();
    start_frame(1'b1);
  endtask

  task automatic test_full_frame();
    start_frame(1'b1);
    for (int r = 0; r < V; r++) drive_line(H, 1'b1);
    // Lines after completion are ignored in DONE.
    drive_line(H, 1'b0);
  endtask

  task automatic test_abort();
    start_frame(1'b1);
    for (int r = 0; r < 40; r++) drive_line(H, 1'b0);
    bus.vref = 1'b0; bus.href2 = 1'b1;
    cycle();
    for (int i = 0; i < 10; i++) begin
      bus.href2_wr = 1'b1; #1;
      n_checks++; if (bus.adr_counter !== 16'(40 * H + i)) begin n_fail++; $display("FAIL abort_pix_adr i=%0d got=%0d exp=%0d", i, bus.adr_counter, 40 * H + i); end
      cycle();
    end
    bus.vref = 1'b1; bus.oddframe = 1'b1; bus.href2_wr = 1'b1;
    cycle();
    model_clear(1'b1);
    n_checks++; if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL abort_start_pulse got=%b exp=1", bus.frame_start); end
    n_checks++; if ({bus.adr_counter, bus.col, bus.row} !== 32'd0) begin n_fail++; $display("FAIL abort_counters got=%0d/%0d/%0d exp=0/0/0", bus.adr_counter, bus.col, bus.row); end
    n_checks++; if ({bus.wr_sel, bus.bank_sel} !== 4'b0010) begin n_fail++; $display("FAIL abort_sel got=%b/%b exp=001/0", bus.wr_sel, bus.bank_sel); end
    bus.href2_wr = 1'b0; bus.href2 = 1'b0;
    cycle();
    n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got=%b exp=0", bus.frame_done); end
    n_checks++; if (bus.adr_counter !== 16'd0) begin n_fail++; $display("FAIL abort_adr_hold got=%0d exp=0", bus.adr_counter); end
    for (int r = 0; r < 4; r++) drive_line(H, 1'b1);
  endtask

  task automatic test_errors();
    start_frame(1'b1);
    drive_line(H, 1'b0);
    drive_line(H, 1'b0);
    drive_line(H + 1, 1'b0);
    drive_line(0, 1'b0);
    drive_line(100, 1'b1);
    drive_line(H, 1'b0);
    drive_line($urandom_range(H - 1, 1), 1'b0);
    // A new accepted start clears the sticky flags.
    start_frame(1'b1);
  endtask

  task automatic test_skip();
    start_frame(1'b1);
    drive_line(H, 1'b0);
    drive_line(H, 1'b0);
    start_frame(1'b0);
    for (int k = 0; k < 10; k++) drive_line(H, 1'b1);
    start_frame(1'b1);
    drive_line(H, 1'b0);
  endtask

  initial begin
    bus.vref = 1'b0; bus.oddframe = 1'b0; bus.href2 = 1'b0; bus.href2_wr = 1'b0;
    model_clear(1'b0);
    test_reset();
    test_full_frame();
    test_abort();
    test_errors();
    test_skip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
